// File: rtl/ex_stage.sv
// ex_stage: execute stage of a 5-stage MIPS-like pipeline.
// Forwards operands from EX/MEM and MEM/WB, runs the ALU and registers the
// EX/MEM pipeline outputs. Define EX_STAGE_ITER_MUL_EN to replace the
// single-cycle multiplier with a 32-step shift-add FSM that stalls upstream.
module ex_stage (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [1:0]  WB_i,
    input  logic [1:0]  M_i,
    input  logic [3:0]  EX_i,
    input  logic [31:0] data1_i,
    input  logic [31:0] data2_i,
    input  logic [31:0] ext_i,
    input  logic [14:0] inst_i,
    input  logic        mem_wb_regwrite_i,
    input  logic [4:0]  mem_wb_rd_i,
    input  logic [31:0] mem_wb_data_i,
    output logic        stall_o,
    output logic [1:0]  WB_o,
    output logic [1:0]  M_o,
    output logic [31:0] alu_o,
    output logic [31:0] wdata_o,
    output logic [4:0]  rd_o
);

    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd_sel;
    logic [1:0]  alu_op;
    logic [5:0]  funct;
    logic        is_mul;
    logic [31:0] fwd_a;
    logic [31:0] fwd_rt;
    logic [31:0] op_b;
    logic [31:0] alu_res;
    logic [31:0] out_res;

    assign rs     = inst_i[14:10];
    assign rt     = inst_i[9:5];
    assign rd_sel = EX_i[3] ? inst_i[4:0] : inst_i[9:5];
    assign alu_op = EX_i[2:1];
    assign funct  = ext_i[5:0];
    assign is_mul = (alu_op == 2'b10) && (funct == 6'h18);

    // Operand forwarding; EX/MEM is newer than MEM/WB so it wins. r0 never forwards.
    always_comb begin
        fwd_a = data1_i;
        if (WB_o[1] && (rd_o != 5'd0) && (rd_o == rs)) begin
            fwd_a = alu_o;
        end else if (mem_wb_regwrite_i && (mem_wb_rd_i != 5'd0) && (mem_wb_rd_i == rs)) begin
            fwd_a = mem_wb_data_i;
        end
        fwd_rt = data2_i;
        if (WB_o[1] && (rd_o != 5'd0) && (rd_o == rt)) begin
            fwd_rt = alu_o;
        end else if (mem_wb_regwrite_i && (mem_wb_rd_i != 5'd0) && (mem_wb_rd_i == rt)) begin
            fwd_rt = mem_wb_data_i;
        end
        op_b = EX_i[0] ? ext_i : fwd_rt;
    end

    // ALU decode; all arithmetic wraps modulo 2^32.
    always_comb begin
        alu_res = 32'd0;
        case (alu_op)
            2'b00:   alu_res = fwd_a + op_b;
            2'b01:   alu_res = fwd_a - op_b;
            2'b11:   alu_res = fwd_a + op_b;
            default: begin
                case (funct)
                    6'h20:   alu_res = fwd_a + op_b;
                    6'h22:   alu_res = fwd_a - op_b;
                    6'h24:   alu_res = fwd_a & op_b;
                    6'h25:   alu_res = fwd_a | op_b;
`ifdef EX_STAGE_ITER_MUL_EN
                    // Product comes from the FSM, not the ALU.
                    6'h18:   alu_res = 32'd0;
`else
                    6'h18:   alu_res = fwd_a * op_b;
`endif
                    default: alu_res = 32'd0;
                endcase
            end
        endcase
    end

`ifdef EX_STAGE_ITER_MUL_EN
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state_q;
    logic [4:0]  count_q;
    logic [31:0] mcand_q;
    logic [31:0] mplier_q;
    logic [31:0] prod_q;

    // Stall from the cycle the mul is seen in IDLE through the last BUSY step.
    assign stall_o = ((state_q == IDLE) && is_mul) || (state_q == BUSY);
    assign out_res = (state_q == DONE) ? prod_q : alu_res;

    // Multiply FSM: capture operands once, then one shift-add step per cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            count_q  <= 5'd0;
            mcand_q  <= 32'd0;
            mplier_q <= 32'd0;
            prod_q   <= 32'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (is_mul) begin
                        mcand_q  <= fwd_a;
                        mplier_q <= op_b;
                        prod_q   <= 32'd0;
                        count_q  <= 5'd0;
                        state_q  <= BUSY;
                    end
                end
                BUSY: begin
                    if (mplier_q[0]) begin
                        prod_q <= prod_q + mcand_q;
                    end
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    count_q  <= count_q + 5'd1;
                    if (count_q == 5'd31) begin
                        state_q <= DONE;
                    end
                end
                // DONE lasts one cycle; upstream advances, so no retrigger.
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
`else
    assign stall_o = 1'b0;
    assign out_res = alu_res;
`endif

    // EX/MEM pipeline register; a stalled edge loads a bubble.
    always_ff @(posedge clk_i) begin
        if (rst_i || stall_o) begin
            WB_o    <= 2'b00;
            M_o     <= 2'b00;
            alu_o   <= 32'd0;
            wdata_o <= 32'd0;
            rd_o    <= 5'd0;
        end else begin
            WB_o    <= WB_i;
            M_o     <= M_i;
            alu_o   <= out_res;
            wdata_o <= fwd_rt;
            rd_o    <= rd_sel;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Directed testbench for ex_stage; works with or without EX_STAGE_ITER_MUL_EN.
module tb_ex_stage;

`ifdef EX_STAGE_ITER_MUL_EN
    localparam int MulStall = 33;
`else
    localparam int MulStall = 0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [1:0]  WB_i, M_i;
    logic [3:0]  EX_i;
    logic [31:0] data1_i, data2_i, ext_i;
    logic [14:0] inst_i;
    logic        mem_wb_regwrite_i;
    logic [4:0]  mem_wb_rd_i;
    logic [31:0] mem_wb_data_i;
    logic        stall_o;
    logic [1:0]  WB_o, M_o;
    logic [31:0] alu_o, wdata_o;
    logic [4:0]  rd_o;

    int passed = 0;
    int total  = 0;

    always #5 clk_i = ~clk_i;

    ex_stage dut (
        .clk_i(clk_i), .rst_i(rst_i), .WB_i(WB_i), .M_i(M_i), .EX_i(EX_i),
        .data1_i(data1_i), .data2_i(data2_i), .ext_i(ext_i), .inst_i(inst_i),
        .mem_wb_regwrite_i(mem_wb_regwrite_i), .mem_wb_rd_i(mem_wb_rd_i),
        .mem_wb_data_i(mem_wb_data_i), .stall_o(stall_o), .WB_o(WB_o), .M_o(M_o),
        .alu_o(alu_o), .wdata_o(wdata_o), .rd_o(rd_o)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic [1:0] wb, input logic [1:0] m, input logic [3:0] ex,
                         input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] ext,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        WB_i = wb; M_i = m; EX_i = ex;
        data1_i = d1; data2_i = d2; ext_i = ext;
        inst_i = {rs, rt, rd};
    endtask

    task automatic set_mem_wb(input logic we, input logic [4:0] rd, input logic [31:0] d);
        mem_wb_regwrite_i = we; mem_wb_rd_i = rd; mem_wb_data_i = d;
    endtask

    task automatic do_reset();
        drive(2'b00, 2'b00, 4'b0000, 0, 0, 0, 0, 0, 0);
        set_mem_wb(1'b0, 5'd0, 32'd0);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        drive(2'b11, 2'b11, 4'b1100, 32'd5, 32'd7, 32'h20, 5'd1, 5'd2, 5'd3);
        set_mem_wb(1'b0, 5'd0, 32'd0);
        rst_i = 1'b1;
        tick();
        total++; if (WB_o !== 2'b00) $display("FAIL reset_wb: got %b expected 00", WB_o); else passed++;
        total++; if (M_o !== 2'b00) $display("FAIL reset_m: got %b expected 00", M_o); else passed++;
        total++; if (alu_o !== 32'd0) $display("FAIL reset_alu: got %h expected 0", alu_o); else passed++;
        total++; if (wdata_o !== 32'd0) $display("FAIL reset_wdata: got %h expected 0", wdata_o); else passed++;
        total++; if (rd_o !== 5'd0) $display("FAIL reset_rd: got %0d expected 0", rd_o); else passed++;
        total++; if (stall_o !== 1'b0) $display("FAIL reset_stall: got %b expected 0", stall_o); else passed++;
        rst_i = 1'b0;
    endtask

    task automatic test_alu();
        do_reset();
        drive(2'b10, 2'b00, 4'b1100, 32'd5, 32'd7, 32'h20, 5'd1, 5'd2, 5'd3);
        tick();
        total++; if (alu_o !== 32'd12) $display("FAIL add_alu: got %0d expected 12", alu_o); else passed++;
        total++; if (rd_o !== 5'd3) $display("FAIL add_rd: got %0d expected 3", rd_o); else passed++;
        total++; if (WB_o !== 2'b10) $display("FAIL add_wb: got %b expected 10", WB_o); else passed++;
        total++; if (wdata_o !== 32'd7) $display("FAIL add_wdata: got %0d expected 7", wdata_o); else passed++;
        // ALUOp 01 = sub, RegDst=0 picks rt as destination
        drive(2'b01, 2'b10, 4'b0010, 32'd20, 32'd7, 32'h0, 5'd10, 5'd11, 5'd12);
        tick();
        total++; if (alu_o !== 32'd13) $display("FAIL sub_alu: got %0d expected 13", alu_o); else passed++;
        total++; if (rd_o !== 5'd11) $display("FAIL regdst0_rd: got %0d expected 11", rd_o); else passed++;
        total++; if (M_o !== 2'b10) $display("FAIL sub_m: got %b expected 10", M_o); else passed++;
        drive(2'b01, 2'b00, 4'b0110, 32'd1, 32'd2, 32'h22, 5'd10, 5'd11, 5'd12);
        tick();
        total++; if (alu_o !== 32'd3) $display("FAIL aluop11_add: got %0d expected 3", alu_o); else passed++;
        drive(2'b01, 2'b00, 4'b1100, 32'hF0, 32'h3C, 32'h24, 5'd10, 5'd11, 5'd12);
        tick();
        total++; if (alu_o !== 32'h30) $display("FAIL and_alu: got %h expected 30", alu_o); else passed++;
        drive(2'b01, 2'b00, 4'b1100, 32'hF0, 32'h0F, 32'h25, 5'd10, 5'd11, 5'd12);
        tick();
        total++; if (alu_o !== 32'hFF) $display("FAIL or_alu: got %h expected ff", alu_o); else passed++;
        drive(2'b01, 2'b00, 4'b1100, 32'hF0, 32'h0F, 32'h26, 5'd10, 5'd11, 5'd12);
        tick();
        total++; if (alu_o !== 32'd0) $display("FAIL bad_funct: got %h expected 0", alu_o); else passed++;
        drive(2'b01, 2'b00, 4'b0010, 32'd0, 32'd1, 32'h0, 5'd10, 5'd11, 5'd12);
        tick();
        total++; if (alu_o !== 32'hFFFF_FFFF) $display("FAIL sub_wrap: got %h expected ffffffff", alu_o); else passed++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive(2'b10, 2'b00, 4'b1100, 32'd5, 32'd7, 32'h20, 5'd1, 5'd2, 5'd3);
        tick();
        // sub r4,r3,r1: r3 from EX/MEM (12) must beat MEM/WB (50); stale data1 ignored
        drive(2'b10, 2'b00, 4'b1100, 32'd99, 32'd2, 32'h22, 5'd3, 5'd1, 5'd4);
        set_mem_wb(1'b1, 5'd3, 32'd50);
        tick();
        total++; if (alu_o !== 32'd10) $display("FAIL fwd_exmem_a: got %0d expected 10", alu_o); else passed++;
        total++; if (rd_o !== 5'd4) $display("FAIL fwd_exmem_rd: got %0d expected 4", rd_o); else passed++;
        // rs from MEM/WB (100), rt from EX/MEM r4 (10)
        drive(2'b10, 2'b00, 4'b1100, 32'd1, 32'd77, 32'h20, 5'd9, 5'd4, 5'd5);
        set_mem_wb(1'b1, 5'd9, 32'd100);
        tick();
        total++; if (alu_o !== 32'd110) $display("FAIL fwd_memwb_a: got %0d expected 110", alu_o); else passed++;
        total++; if (wdata_o !== 32'd10) $display("FAIL fwd_rt_wdata: got %0d expected 10", wdata_o); else passed++;
    endtask

    task automatic test_rd_zero();
        do_reset();
        drive(2'b10, 2'b00, 4'b1100, 32'd5, 32'd7, 32'h20, 5'd1, 5'd2, 5'd0);
        tick();
        drive(2'b10, 2'b00, 4'b1100, 32'd9, 32'd1, 32'h20, 5'd0, 5'd3, 5'd6);
        tick();
        total++; if (alu_o !== 32'd10) $display("FAIL rd0_exmem: got %0d expected 10", alu_o); else passed++;
        drive(2'b10, 2'b00, 4'b1100, 32'd4, 32'd1, 32'h20, 5'd0, 5'd3, 5'd7);
        set_mem_wb(1'b1, 5'd0, 32'h55);
        tick();
        total++; if (alu_o !== 32'd5) $display("FAIL rd0_memwb: got %0d expected 5", alu_o); else passed++;
    endtask

    task automatic test_store();
        do_reset();
        set_mem_wb(1'b1, 5'd5, 32'hAB);
        drive(2'b00, 2'b01, 4'b0001, 32'h100, 32'h33, 32'd8, 5'd2, 5'd5, 5'd0);
        tick();
        total++; if (alu_o !== 32'h108) $display("FAIL sw_alu: got %h expected 108", alu_o); else passed++;
        total++; if (wdata_o !== 32'hAB) $display("FAIL sw_wdata: got %h expected ab", wdata_o); else passed++;
        total++; if (M_o !== 2'b01) $display("FAIL sw_m: got %b expected 01", M_o); else passed++;
    endtask

    task automatic test_mul();
        int cyc;
        do_reset();
        drive(2'b10, 2'b00, 4'b1100, 32'hFFFF_FFFF, 32'd3, 32'h18, 5'd1, 5'd2, 5'd7);
        #1;
        for (int i = 0; i < MulStall; i++) begin
            total++; if (stall_o !== 1'b1) $display("FAIL mul_stall cyc %0d: got %b expected 1", i, stall_o); else passed++;
            tick();
            total++;
            if ({WB_o, M_o, alu_o, wdata_o, rd_o} !== 73'd0)
                $display("FAIL mul_bubble cyc %0d: got wb=%b alu=%h rd=%0d expected zeros", i, WB_o, alu_o, rd_o);
            else passed++;
            // Captured operands must not follow later input changes
            if (i == 0) begin
                data1_i = 32'd0; data2_i = 32'd0;
                set_mem_wb(1'b1, 5'd1, 32'd5);
            end
        end
        total++; if (stall_o !== 1'b0) $display("FAIL mul_done_stall: got %b expected 0", stall_o); else passed++;
        tick();
        total++; if (alu_o !== 32'hFFFF_FFFD) $display("FAIL mul_result: got %h expected fffffffd", alu_o); else passed++;
        total++; if (rd_o !== 5'd7) $display("FAIL mul_rd: got %0d expected 7", rd_o); else passed++;
        total++; if (WB_o !== 2'b10) $display("FAIL mul_wb: got %b expected 10", WB_o); else passed++;
        // A second mul right after the first starts fresh
        set_mem_wb(1'b0, 5'd0, 32'd0);
        drive(2'b10, 2'b00, 4'b1100, 32'd6, 32'd7, 32'h18, 5'd11, 5'd12, 5'd8);
        #1;
        cyc = 0;
        while (stall_o && cyc < 50) begin
            tick();
            cyc++;
        end
        total++; if (cyc != MulStall) $display("FAIL mul2_stall_len: got %0d expected %0d", cyc, MulStall); else passed++;
        tick();
        total++; if (alu_o !== 32'd42) $display("FAIL mul2_result: got %0d expected 42", alu_o); else passed++;
    endtask

    task automatic test_mul_reset();
        int cyc;
        do_reset();
        drive(2'b10, 2'b00, 4'b1100, 32'hFFFF_FFFF, 32'd3, 32'h18, 5'd1, 5'd2, 5'd7);
        repeat (11) tick();
        drive(2'b00, 2'b00, 4'b0000, 0, 0, 0, 0, 0, 0);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        total++; if ({WB_o, M_o, alu_o, wdata_o, rd_o} !== 73'd0)
            $display("FAIL mulrst_outputs: got wb=%b alu=%h rd=%0d expected zeros", WB_o, alu_o, rd_o);
        else passed++;
        total++; if (stall_o !== 1'b0) $display("FAIL mulrst_stall: got %b expected 0", stall_o); else passed++;
        tick();
        total++; if (alu_o !== 32'd0) $display("FAIL mulrst_no_partial: got %h expected 0", alu_o); else passed++;
        drive(2'b10, 2'b00, 4'b1100, 32'd6, 32'd7, 32'h18, 5'd1, 5'd2, 5'd9);
        #1;
        cyc = 0;
        while (stall_o && cyc < 50) begin
            tick();
            cyc++;
        end
        total++; if (cyc != MulStall) $display("FAIL mulrst_stall_len: got %0d expected %0d", cyc, MulStall); else passed++;
        tick();
        total++; if (alu_o !== 32'd42) $display("FAIL mulrst_result: got %0d expected 42", alu_o); else passed++;
        total++; if (rd_o !== 5'd9) $display("FAIL mulrst_rd: got %0d expected 9", rd_o); else passed++;
    endtask

    initial begin
        rst_i = 1'b0;
        drive(2'b00, 2'b00, 4'b0000, 0, 0, 0, 0, 0, 0);
        set_mem_wb(1'b0, 5'd0, 32'd0);
        test_reset();
        test_alu();
        test_back_to_back();
        test_rd_zero();
        test_store();
        test_mul();
        test_mul_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have ports WB_i[1:0] (in, [1]=RegWrite, [0]=MemtoReg) and M_i[1:0] (in, [1]=MemRead, [0]=MemWrite).
REQ-004 SHALL have port EX_i[3:0], input: [3]=RegDst, [2:1]=ALUOp, [0]=ALUSrc.
REQ-005 SHALL have ports data1_i, data2_i, ext_i, each input, 32 bits: rs value, rt value, sign-extended immediate; ext_i[5:0] is funct.
REQ-006 SHALL have port inst_i[14:0], input: [14:10]=rs, [9:5]=rt, [4:0]=rd.
REQ-007 SHALL have ports mem_wb_regwrite_i (1), mem_wb_rd_i (5), mem_wb_data_i (32), all inputs: the MEM/WB write-back forwarding source.
REQ-008 SHALL have port stall_o, output, 1 bit: while high, the upstream ID/EX and earlier stages hold their contents.
REQ-009 SHALL have registered outputs WB_o[1:0], M_o[1:0], alu_o[31:0], wdata_o[31:0] (forwarded rt, for stores), rd_o[4:0] (destination register).

Function
REQ-010 SHALL select destination = RegDst ? inst_i[4:0] : inst_i[9:5].
REQ-011 SHALL forward operand A: EX/MEM if WB_o[1], rd_o!=0 and rd_o==rs; else MEM/WB if mem_wb_regwrite_i, mem_wb_rd_i!=0 and ==rs; else data1_i. EX/MEM has priority over MEM/WB.
REQ-012 SHALL forward the rt value by the same rule as REQ-011; operand B = ALUSrc ? ext_i : forwarded rt.
REQ-013 SHALL decode ALUOp 00=add, 01=sub, 11=add; for ALUOp 10, funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x18 mul (low 32 bits), any other funct gives result 0.
REQ-014 SHALL wrap add/sub/mul modulo 2^32, with no overflow flag or trap.
REQ-015 For non-mul operations, SHALL latch WB_i, M_i, result, forwarded rt and destination into the outputs at every non-stalled edge (1-cycle latency).
REQ-016 SHALL implement the multiply FSM with states IDLE, BUSY, DONE.
REQ-017 In IDLE with a mul present, SHALL assert stall_o combinationally, capture both forwarded operands, clear the iteration count, and go to BUSY at the next edge.
REQ-018 In BUSY, SHALL perform one shift-add step per cycle for 32 cycles (count 0..31) with stall_o high, then go to DONE after count 31.
REQ-019 In DONE, SHALL drive stall_o low, latch the product with the mul's WB/M/rd into the outputs, and return to IDLE; DONE SHALL NOT retrigger on the same instruction.
REQ-020 A mul issued at cycle N SHALL hold stall_o high for cycles N..N+32 (33 cycles); the product SHALL appear on alu_o after the N+33 edge.
REQ-021 While stall_o is high, SHALL load a bubble at each edge: WB_o=0, M_o=0, alu_o, wdata_o and rd_o at 0.
REQ-022 The captured operands SHALL NOT change during BUSY, regardless of the forwarding inputs.
REQ-023 A mul arriving in the cycle immediately after DONE SHALL start a fresh multiply from IDLE.

Reset
REQ-024 While rst_i=1 at an edge, SHALL clear all outputs and internal registers to 0, set the FSM to IDLE, and drive stall_o=0 in the following cycle.
REQ-025 A reset during BUSY or DONE SHALL abort the multiply and SHALL NOT emit a partial product.

Configuration
REQ-026 With macro EX_STAGE_ITER_MUL_EN defined, SHALL use the iterative FSM multiplier of REQ-016..REQ-023.
REQ-027 Without EX_STAGE_ITER_MUL_EN, SHALL compute mul combinationally with 1-cycle latency like other operations, tie stall_o to 0, and omit the FSM.

Verification
REQ-028 add: data1=5, data2=7, ALUOp=10, funct=0x20, RegDst=1, rd=3 -> after 1 edge alu_o=12, rd_o=3, WB_o=WB_i.
REQ-029 Back-to-back dependency: add r3 then sub r4,r3,r1 with r1=2 -> second result 10 via EX/MEM forwarding; with both sources matching rs, the EX/MEM value SHALL win.
REQ-030 Iterative mul: 0xFFFF_FFFF x 3 with macro defined -> stall_o high 33 cycles, bubbles during that time, then alu_o=0xFFFF_FFFD; without macro -> result after 1 edge, stall_o always 0.
REQ-031 Reset at BUSY count 10 -> next cycle all outputs 0, stall_o=0; a fresh mul 6x7 then yields 42.
REQ-032 Forwarding with rd 0: EX/MEM rd_o=0 with RegWrite=1 and rs=0 -> operand A = data1_i, not forwarded.
REQ-033 sw with ALUSrc=1, ext=8, rt matching mem_wb_rd_i=5 with data 0xAB -> alu_o=data1+8, wdata_o=0xAB.
